// File: rtl/fifo_arb_pkg.sv
// Shared types for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible index after `last`, wrapping.
module rr_pick #(
    parameter int NUM_P = 4,
    localparam int IW   = $clog2(NUM_P)
) (
    input  logic [NUM_P-1:0] eligible,
    input  logic [IW-1:0]    last,
    output logic             found,
    output logic [IW-1:0]    winner
);

    // i runs 1..NUM_P so `last` itself is considered last
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 1; i <= NUM_P; i++) begin
            if (!found && eligible[(int'(last) + i) % NUM_P]) begin
                found  = 1'b1;
                winner = IW'((int'(last) + i) % NUM_P);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arb.sv
// Round-robin arbiter granting one producer a bounded burst onto a shared FIFO
// write port; only the granted producer sees backpressure.
module fifo_rr_arb
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int NUM_P   = 4,
    parameter int BURST_P = 16,
    localparam int IW     = $clog2(NUM_P),
    localparam int CW     = $clog2(BURST_P + 1)
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [NUM_P*WIDTH_P-1:0] data_i,
    input  logic [NUM_P-1:0]         valid_i,
    output logic [NUM_P-1:0]         ready_o,
    input  logic [NUM_P-1:0]         mask_i,
    output logic [WIDTH_P-1:0]       data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [NUM_P-1:0]         grant_o,
    output logic [IW-1:0]            id_o
);

    arb_state_e    state, state_nxt;
    logic [IW-1:0] g;
    logic [IW-1:0] last;
    logic [CW-1:0] count;

    logic          found;
    logic [IW-1:0] winner;
    logic          beat;
    logic          last_beat;

    rr_pick #(.NUM_P(NUM_P)) u_pick (
        .eligible (valid_i & ~mask_i),
        .last     (last),
        .found    (found),
        .winner   (winner)
    );

    assign beat      = (state == ARB_GRANT) && valid_i[g] && ready_i;
    assign last_beat = beat && (count == CW'(BURST_P - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= ARB_IDLE;
        else         state <= state_nxt;
    end

    // A granted requester dropping valid ends its burst; mask_i is ignored here
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (found) state_nxt = ARB_GRANT;
            ARB_GRANT: if (!valid_i[g] || last_beat) state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant_o = '0;
        ready_o = '0;
        id_o    = '0;
        valid_o = 1'b0;
        data_o  = '0;
        if (state == ARB_GRANT) begin
            grant_o[g] = 1'b1;
            ready_o[g] = ready_i;
            id_o       = g;
            valid_o    = valid_i[g];
            data_o     = data_i[g*WIDTH_P +: WIDTH_P];
        end
    end

    // last resets to NUM_P-1 so requester 0 wins the first arbitration
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            g     <= '0;
            last  <= IW'(NUM_P - 1);
            count <= '0;
        end else if (state == ARB_IDLE) begin
            if (found) begin
                g     <= winner;
                last  <= winner;
                count <= '0;
            end
        end else if (beat) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rr_arb.sv
// Directed bench for fifo_rr_arb (NUM_P=4, WIDTH_P=8, BURST_P=4) with a FIFO capture model.
module tb_fifo_rr_arb;

    localparam int W = 8;
    localparam int N = 4;
    localparam int B = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N*W-1:0]   data_i;
    logic [N-1:0]     valid_i, mask_i, ready_o, grant_o;
    logic [W-1:0]     data_o;
    logic             valid_o, ready_i;
    logic [1:0]       id_o;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] exp_q[$];

    fifo_rr_arb #(.WIDTH_P(W), .NUM_P(N), .BURST_P(B)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mask_i  (mask_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .grant_o (grant_o),
        .id_o    (id_o)
    );

    always #5 clk = ~clk;

    // FIFO write-side model: accepts whatever is presented while it is ready
    always @(negedge clk) if (valid_o && ready_i) q.push_back(data_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_beat(input string tag, input int k, input logic v, input logic r);
        logic [N-1:0] oh;
        oh = '0;
        oh[k] = 1'b1;
        chk({tag, "_grant"}, grant_o, oh);
        chk({tag, "_id"},    id_o, k);
        chk({tag, "_valid"}, valid_o, v);
        chk({tag, "_ready"}, ready_o, r ? oh : '0);
        chk({tag, "_data"},  data_o, 8'h10 + k);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_id"},    id_o, 0);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_ready"}, ready_o, 0);
        chk({tag, "_data"},  data_o, 0);
    endtask

    task automatic chk_q(input string tag);
        chk({tag, "_qsize"}, q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < q.size(); i++)
            chk($sformatf("%s_q%0d", tag, i), q[i], exp_q[i]);
        q.delete();
        exp_q.delete();
    endtask

    initial begin
        int order1[5] = '{0, 1, 2, 3, 0};

        rstn    = 1'b0;
        data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        valid_i = '0;
        mask_i  = '0;
        ready_i = 1'b0;
        #1;
        chk_idle("reset");
        step();
        step();
        rstn = 1'b1;

        // all valid, bursts of 4 in order 0,1,2,3,0 with one idle cycle between
        ready_i = 1'b1;
        valid_i = 4'hF;
        #1;
        chk_idle("t1_arb");
        step();
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < B; i++) begin
                chk_beat($sformatf("t1_b%0d_%0d", b, i), order1[b], 1'b1, 1'b1);
                exp_q.push_back(W'(8'h10 + order1[b]));
                step();
            end
            chk_idle($sformatf("t1_gap%0d", b));
            if (b == 4) valid_i = '0;
            step();
        end
        chk_idle("t1_end");
        chk_q("t1");

        // only requester 2, three beats then valid drops
        valid_i = 4'b0100;
        step();
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("t2_b%0d", i), 2, 1'b1, 1'b1);
            exp_q.push_back(8'h12);
            step();
        end
        valid_i = '0;
        #1;
        chk_beat("t2_drop", 2, 1'b0, 1'b1);
        step();
        chk_idle("t2_rel");
        chk_q("t2");

        // requester 1 stalled 10 cycles after one beat, then completes 3 more
        valid_i = 4'b0010;
        step();
        chk_beat("t3_b0", 1, 1'b1, 1'b1);
        exp_q.push_back(8'h11);
        step();
        ready_i = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk_beat($sformatf("t3_stall%0d", i), 1, 1'b1, 1'b0);
            step();
        end
        ready_i = 1'b1;
        #1;
        for (int i = 1; i < B; i++) begin
            chk_beat($sformatf("t3_b%0d", i), 1, 1'b1, 1'b1);
            exp_q.push_back(8'h11);
            step();
        end
        chk_idle("t3_rel");
        valid_i = '0;
        step();
        chk_q("t3");

        // mask 0101: last winner 1, so 3 then 1; masking 1 mid-burst keeps it going
        mask_i  = 4'b0101;
        valid_i = 4'hF;
        step();
        for (int i = 0; i < B; i++) begin
            chk_beat($sformatf("t4_a%0d", i), 3, 1'b1, 1'b1);
            exp_q.push_back(8'h13);
            step();
        end
        chk_idle("t4_gap0");
        step();
        chk_beat("t4_b0", 1, 1'b1, 1'b1);
        exp_q.push_back(8'h11);
        step();
        mask_i = 4'b0111;
        #1;
        for (int i = 1; i < B; i++) begin
            chk_beat($sformatf("t4_b%0d", i), 1, 1'b1, 1'b1);
            exp_q.push_back(8'h11);
            step();
        end
        chk_idle("t4_gap1");
        step();
        chk_beat("t4_c0", 3, 1'b1, 1'b1);
        exp_q.push_back(8'h13);
        step();

        // async reset mid-burst on requester 3: outputs drop before the next edge
        rstn = 1'b0;
        #1;
        chk_idle("t5_rst");
        chk_q("t4");
        step();
        step();
        rstn    = 1'b1;
        mask_i  = '0;
        valid_i = 4'hF;
        #1;
        chk_idle("t5_arb");
        step();
        chk_beat("t5_first", 0, 1'b1, 1'b1);
        valid_i = '0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
